// File: rtl/parking_allocator.sv
// Two-gate, two-floor parking spot allocator: round-robin between gates,
// linear scan for the lowest free spot, and a grant that waits for ack, withdrawal or timeout.
module parking_allocator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        ack,
    input  logic        rel_valid,
    input  logic [3:0]  rel_idx,
    output logic        grant_a,
    output logic        grant_b,
    output logic [3:0]  floor,
    output logic [3:0]  spot,
    output logic [15:0] occ,
    output logic [4:0]  count,
    output logic        full,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

    state_t      state, next;
    logic        win_b;     // latched winner: 1 = gate B
    logic        last_b;    // last served: 1 = gate B
    logic [3:0]  idx;
    logic [7:0]  timer;
    logic [15:0] occ_n;
    logic        win_req, start, found, accept, abandon, timed_out, rel_clr;

    always_comb begin
        win_req   = win_b ? req_b : req_a;
        start     = (state == IDLE) && (req_a || req_b) && !full;
        found     = (state == SCAN) && !occ[idx];
        timed_out = (timer == 8'(TIMEOUT - 1));
        accept    = (state == GRANT) && ack;
        abandon   = (state == GRANT) && !ack && (!win_req || timed_out);
        rel_clr   = rel_valid && occ[rel_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = SCAN;
            SCAN:    if (found) next = GRANT;
            GRANT:   if (accept || abandon) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        grant_a = (state == GRANT) && !win_b;
        grant_b = (state == GRANT) && win_b;
        if (state == GRANT) begin
            floor = 4'({3'b000, idx[3]} + 4'd1);
            spot  = {1'b0, idx[2:0]} + 4'd1;
        end else begin
            floor = 4'b1000;
            spot  = 4'b1000;
        end
        full = (count == 5'd16);
        busy = (state != IDLE);
    end

    // After reset B counts as last served so A wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_b  <= 1'b0;
            last_b <= 1'b1;
            idx    <= 4'd0;
            timer  <= 8'd0;
        end else begin
            if (start) begin
                win_b <= !(req_a && (!req_b || last_b));
                idx   <= 4'd0;
            end
            if (state == SCAN && !found) idx <= idx + 4'd1;
            if (found)                 timer <= 8'd0;
            else if (state == GRANT)   timer <= timer + 8'd1;
            if (accept || abandon)     last_b <= win_b;
        end
    end

    // Release clears first, ack sets second, so releasing the latched idx is a no-op.
    always_comb begin
        occ_n = occ;
        if (rel_clr) occ_n[rel_idx] = 1'b0;
        if (accept)  occ_n[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ   <= 16'd0;
            count <= 5'd0;
        end else begin
            occ   <= occ_n;
            count <= count + 5'(accept) - 5'(rel_clr);
        end
    end

endmodule

// File: tb/tb_parking_allocator.sv
// Randomized self-checking bench for parking_allocator against a
// transaction-level model of occupancy, round-robin and scan latency.
module tb_parking_allocator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, ack = 1'b0, rel_valid = 1'b0;
    logic [3:0]  rel_idx = 4'd0;
    logic        grant_a, grant_b, full, busy;
    logic [3:0]  floor, spot;
    logic [15:0] occ;
    logic [4:0]  count;

    int n_pass = 0;
    int n_total = 0;

    // model state
    bit  m_occ[16];
    int  m_count;
    int  m_last;   // 0 = A served last, 1 = B

    parking_allocator #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .ack(ack),
        .rel_valid(rel_valid), .rel_idx(rel_idx), .grant_a(grant_a), .grant_b(grant_b),
        .floor(floor), .spot(spot), .occ(occ), .count(count), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_occ[i]) m_occ[i] = 1'b0;
        m_count = 0;
        m_last  = 1;
    endtask

    function automatic logic [15:0] m_map();
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) m[i] = m_occ[i];
        return m;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < 16; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic int pick(input bit ra, input bit rb);
        if (ra && !rb) return 0;
        if (rb && !ra) return 1;
        return (m_last == 0) ? 1 : 0;
    endfunction

    task automatic release_spot(input int i);
        rel_valid = 1'b1;
        rel_idx   = 4'(i);
        step();
        rel_valid = 1'b0;
        if (m_occ[i]) begin m_occ[i] = 1'b0; m_count--; end
        n_total++;
        if (occ !== m_map() || count !== 5'(m_count))
            $display("FAIL release occ=%h count=%0d expected occ=%h count=%0d", occ, count, m_map(), m_count);
        else n_pass++;
    endtask

    // One request transaction: wait for the grant, then ack it or withdraw.
    task automatic serve(input bit ra, input bit rb, input bit do_ack, input bit drop,
                         input bit rel, input int ridx);
        int w, k, cyc;
        w = pick(ra, rb);
        k = first_free();
        req_a = ra;
        req_b = rb;
        cyc = 0;
        while (!(grant_a || grant_b) && cyc < 40) begin step(); cyc++; end
        n_total++;
        if (cyc !== k + 2) $display("FAIL latency got %0d expected %0d", cyc, k + 2);
        else n_pass++;
        n_total++;
        if (grant_a !== (w == 0) || grant_b !== (w == 1))
            $display("FAIL winner grant_a=%b grant_b=%b expected winner %0d", grant_a, grant_b, w);
        else n_pass++;
        n_total++;
        if (floor !== 4'(k / 8 + 1) || spot !== 4'(k % 8 + 1))
            $display("FAIL offer floor=%0d spot=%0d expected %0d/%0d", floor, spot, k / 8 + 1, k % 8 + 1);
        else n_pass++;
        if (do_ack) begin
            ack = 1'b1;
            rel_valid = rel;
            rel_idx = 4'(ridx);
            step();
            ack = 1'b0;
            rel_valid = 1'b0;
            if (rel && m_occ[ridx]) begin m_occ[ridx] = 1'b0; m_count--; end
            m_occ[k] = 1'b1;
            m_count++;
        end else begin
            if (w == 0) req_a = 1'b0; else req_b = 1'b0;
            step();
            n_total++;
            if (grant_a !== 1'b0 || grant_b !== 1'b0)
                $display("FAIL withdraw grant_a=%b grant_b=%b expected 0/0", grant_a, grant_b);
            else n_pass++;
        end
        m_last = w;
        if (drop) begin req_a = 1'b0; req_b = 1'b0; end
        n_total++;
        if (occ !== m_map() || count !== 5'(m_count))
            $display("FAIL after_serve occ=%h count=%0d expected occ=%h count=%0d", occ, count, m_map(), m_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        n_total++;
        if (grant_a !== 0 || grant_b !== 0 || floor !== 4'b1000 || spot !== 4'b1000 ||
            occ !== 16'h0 || count !== 5'd0 || full !== 0 || busy !== 0)
            $display("FAIL reset_state g=%b%b f=%b s=%b occ=%h cnt=%0d full=%b busy=%b expected idle zeros",
                     grant_a, grant_b, floor, spot, occ, count, full, busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        serve(1, 0, 1, 1, 0, 0);
        n_total++;
        if (occ !== 16'h0001 || count !== 5'd1)
            $display("FAIL basic occ=%h count=%0d expected 0001/1", occ, count);
        else n_pass++;
    endtask

    task automatic test_floor2();
        for (int i = 1; i < 8; i++) serve(1, 0, 1, 1, 0, 0);
        serve(0, 1, 1, 1, 0, 0);
        n_total++;
        if (occ !== 16'h01FF) $display("FAIL floor2 occ=%h expected 01ff", occ);
        else n_pass++;
        for (int i = 0; i < 9; i++) release_spot(i);
    endtask

    task automatic test_alternate();
        int w;
        for (int i = 0; i < 4; i++) begin
            w = pick(1, 1);
            n_total++;
            if (w !== i % 2) $display("FAIL rr_model order %0d expected %0d", w, i % 2);
            else n_pass++;
            serve(1, 1, 1, (i == 3), 0, 0);
        end
        n_total++;
        if (occ !== 16'h000F) $display("FAIL alternate occ=%h expected 000f", occ);
        else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 4; i < 16; i++) serve(1, 0, 1, 1, 0, 0);
        n_total++;
        if (full !== 1'b1 || count !== 5'd16) $display("FAIL full full=%b count=%0d expected 1/16", full, count);
        else n_pass++;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (grant_a || grant_b || busy || floor !== 4'b1000 || spot !== 4'b1000)
                $display("FAIL full_nogrant g=%b%b busy=%b f=%b s=%b expected idle", grant_a, grant_b, busy, floor, spot);
            else n_pass++;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        release_spot(9);
        serve(1, 0, 1, 1, 0, 0);
        n_total++;
        if (occ !== 16'hFFFF) $display("FAIL refill occ=%h expected ffff", occ);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int w, k, cyc, hi;
        release_spot(0);
        release_spot(5);
        w = pick(1, 1);
        k = first_free();
        req_a = 1'b1;
        req_b = 1'b1;
        cyc = 0;
        while (!(grant_a || grant_b) && cyc < 40) begin step(); cyc++; end
        hi = 0;
        while ((grant_a || grant_b) && hi < 40) begin
            if ((w == 0 && !grant_a) || (w == 1 && !grant_b)) break;
            step();
            hi++;
        end
        n_total++;
        if (hi !== 4 || cyc !== k + 2) $display("FAIL timeout high=%0d lat=%0d expected 4/%0d", hi, cyc, k + 2);
        else n_pass++;
        n_total++;
        if (occ !== m_map()) $display("FAIL timeout_occ occ=%h expected %h", occ, m_map());
        else n_pass++;
        m_last = w;
        serve(1, 1, 1, 1, 0, 0);
        n_total++;
        if (m_last !== 1 - w) $display("FAIL timeout_next winner %0d expected %0d", m_last, 1 - w);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ra, rb;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < int'($urandom_range(0, 2)); r++) release_spot(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                ack = 1'b1;
                step();
                ack = 1'b0;
                n_total++;
                if (occ !== m_map() || count !== 5'(m_count))
                    $display("FAIL stray_ack occ=%h count=%0d expected %h/%0d", occ, count, m_map(), m_count);
                else n_pass++;
            end
            ra = 1'($urandom_range(0, 1));
            rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_count == 16) begin
                req_a = ra;
                req_b = rb;
                step();
                step();
                n_total++;
                if (grant_a || grant_b || busy) $display("FAIL rand_full g=%b%b busy=%b expected none", grant_a, grant_b, busy);
                else n_pass++;
                req_a = 1'b0;
                req_b = 1'b0;
            end else begin
                serve(ra, rb, ($urandom_range(0, 3) != 0), 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        if (m_count == 16) release_spot(3);
        req_a = 1'b1;
        cyc = 0;
        while (!grant_a && cyc < 40) begin step(); cyc++; end
        n_total++;
        if (grant_a !== 1'b1) $display("FAIL mid_grant_setup grant_a=%b expected 1", grant_a);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (grant_a !== 0 || grant_b !== 0 || floor !== 4'b1000 || spot !== 4'b1000 ||
            occ !== 16'h0 || count !== 5'd0 || full !== 0 || busy !== 0)
            $display("FAIL async_reset g=%b%b f=%b s=%b occ=%h cnt=%0d busy=%b expected reset values",
                     grant_a, grant_b, floor, spot, occ, count, busy);
        else n_pass++;
        req_a = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step();
        serve(1, 1, 1, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor2();
        test_alternate();
        test_full();
        test_timeout();
        test_random();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
